// File: rtl/spike_train_gen.sv
// spike_train_gen: rate-decodes one spike count per sample into a T_STEPS-long
// bit-serial spike train. Spikes are spread evenly over the window by an
// error accumulator, so a count of c yields exactly min(c, T_STEPS) spikes.
// Valid/ready handshake on both the count input and the spike output.

module spike_train_gen #(
   parameter int unsigned  COUNT_WIDTH = 4,
   parameter int unsigned  T_STEPS     = 4,
   localparam int unsigned STEP_W      = (T_STEPS > 1) ? $clog2(T_STEPS) : 1,
   localparam int unsigned ACC_W       = $clog2(2 * T_STEPS) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [COUNT_WIDTH-1:0] cnt_in,
   input  logic                   cnt_valid,
   output logic                   cnt_ready,
   output logic                   spike_out,
   output logic                   spike_valid,
   input  logic                   spike_ready,
   output logic [STEP_W-1:0]      step_idx,
   output logic                   spike_last
);

   localparam logic [ACC_W-1:0] T_ACC = ACC_W'(T_STEPS);
   // With a single-step window every step is also the last one.
   localparam logic FIRST_IS_LAST = (T_STEPS == 32'd1);

   typedef enum logic [0:0] {StIdle, StEmit} state_e;

   state_e              state_q;
   logic [ACC_W-1:0]    cnt_q;
   logic [ACC_W-1:0]    acc_q;
   logic                spike_q;
   logic                valid_q;
   logic                last_q;
   logic [STEP_W-1:0]   step_q;

   logic [ACC_W-1:0]    sat_cnt;
   logic [ACC_W-1:0]    first_sum;
   logic [ACC_W-1:0]    first_acc;
   logic                first_spike;
   logic [ACC_W-1:0]    next_sum;
   logic [ACC_W-1:0]    next_acc;
   logic                next_spike;
   logic [STEP_W-1:0]   next_step;
   logic                next_last;
   logic                load_first;
   logic                advance;

   // Saturate the incoming count to the window length.
   always_comb begin
      sat_cnt = '0;
      if (32'(cnt_in) > T_STEPS) begin
         sat_cnt = T_ACC;
      end else begin
         sat_cnt = ACC_W'(cnt_in);
      end
   end

   // Step 0 of a new sample starts from a cleared accumulator; later steps
   // carry the residue of the previous step.
   always_comb begin
      first_sum   = sat_cnt;
      first_spike = (first_sum >= T_ACC);
      first_acc   = first_spike ? (first_sum - T_ACC) : first_sum;
      next_sum    = acc_q + cnt_q;
      next_spike  = (next_sum >= T_ACC);
      next_acc    = next_spike ? (next_sum - T_ACC) : next_sum;
      next_step   = step_q + STEP_W'(1);
      next_last   = (32'(next_step) == (T_STEPS - 1));
   end

   // A new count is taken when idle, or in the same cycle the final step of
   // the current sample is consumed, which keeps back-to-back samples gapless.
   assign cnt_ready  = (state_q == StIdle) || (valid_q && last_q && spike_ready);
   assign load_first = cnt_valid && cnt_ready;
   assign advance    = (state_q == StEmit) && spike_ready;

   // FSM and registered step outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         spike_q <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         step_q  <= '0;
      end else if (load_first) begin
         state_q <= StEmit;
         cnt_q   <= sat_cnt;
         acc_q   <= first_acc;
         spike_q <= first_spike;
         valid_q <= 1'b1;
         last_q  <= FIRST_IS_LAST;
         step_q  <= '0;
      end else if (advance) begin
         if (last_q) begin
            // Window finished with no follow-on count: fall back to idle.
            state_q <= StIdle;
            acc_q   <= '0;
            spike_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            step_q  <= '0;
         end else begin
            acc_q   <= next_acc;
            spike_q <= next_spike;
            last_q  <= next_last;
            step_q  <= next_step;
         end
      end
   end

   assign spike_out   = spike_q;
   assign spike_valid = valid_q;
   assign spike_last  = last_q;
   assign step_idx    = step_q;

endmodule
